// File: rtl/vote_pkg.sv
// Shared types and sizing helpers for the sequential vote tally engine.
// Optional tie flag is enabled by defining VOTE_TIE_FLAG_EN.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int num_cand(input int n);
        return 1 << n;
    endfunction

    function automatic int num_voter(input int m);
        return 1 << m;
    endfunction

    // One extra bit so a unanimous election (2**M votes) never wraps.
    function automatic int cnt_w(input int m);
        return m + 1;
    endfunction

endpackage

// File: rtl/tally_counter_bank.sv
// Per-candidate vote counters with synchronous clear, single increment
// port and a read port used by the serial winner scan.
module tally_counter_bank
    import vote_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_en_i,
    input  logic [N-1:0]     inc_idx_i,
    input  logic [N-1:0]     rd_idx_i,
    output logic [cnt_w(M)-1:0] rd_cnt_o
);

    localparam int NC = num_cand(N);
    localparam int W  = cnt_w(M);

    logic [W-1:0] cnt_q [NC];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < NC; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_en_i) begin
            cnt_q[inc_idx_i] <= cnt_q[inc_idx_i] + W'(1);
        end
    end

    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/vote_tally_ctrl.sv
// Sequential tally controller: collects 2**M votes, then scans the bank.
// Define VOTE_TIE_FLAG_EN to add the tie output.
module vote_tally_ctrl
    import vote_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         vote_valid,
    input  logic [N-1:0] vote,
    output logic         vote_ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [M:0]   winner_count
`ifdef VOTE_TIE_FLAG_EN
    ,
    output logic         tie
`endif
);

    localparam int NC = num_cand(N);
    localparam int NV = num_voter(M);
    localparam int W  = cnt_w(M);

    state_e       state_q, state_d;
    logic [W-1:0] vcnt_q, vcnt_d;
    logic [N-1:0] idx_q, idx_d;
    logic [N-1:0] best_idx_q, best_idx_d;
    logic [W-1:0] best_cnt_q, best_cnt_d;
    logic [N-1:0] winner_q, winner_d;
    logic [W-1:0] wcnt_q, wcnt_d;
`ifdef VOTE_TIE_FLAG_EN
    logic         tie_q, tie_d;
`endif

    logic         accept;
    logic         bank_clr;
    logic         take;
    logic [W-1:0] rd_cnt;

    assign accept = vote_valid && (state_q == COLLECT);

    tally_counter_bank #(
        .N (N),
        .M (M)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (bank_clr),
        .inc_en_i  (accept),
        .inc_idx_i (vote),
        .rd_idx_i  (idx_q),
        .rd_cnt_o  (rd_cnt)
    );

    // Strict compare keeps the lowest index on ties; idx 0 always seeds.
    assign take = (idx_q == '0) || (rd_cnt > best_cnt_q);

    always_comb begin
        state_d    = state_q;
        vcnt_d     = vcnt_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_cnt_d = best_cnt_q;
        winner_d   = winner_q;
        wcnt_d     = wcnt_q;
        bank_clr   = 1'b0;
`ifdef VOTE_TIE_FLAG_EN
        tie_d      = tie_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = COLLECT;
                    bank_clr   = 1'b1;
                    vcnt_d     = '0;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_cnt_d = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    vcnt_d = vcnt_q + W'(1);
                    if (vcnt_q == W'(NV - 1)) begin
                        state_d = SCAN;
                        idx_d   = '0;
                    end
                end
            end
            SCAN: begin
                if (take) begin
                    best_idx_d = idx_q;
                    best_cnt_d = rd_cnt;
`ifdef VOTE_TIE_FLAG_EN
                    tie_d      = 1'b0;
                end else if (rd_cnt == best_cnt_q) begin
                    tie_d      = 1'b1;
`endif
                end
                idx_d = idx_q + N'(1);
                if (idx_q == N'(NC - 1)) begin
                    state_d  = DONE;
                    winner_d = take ? idx_q : best_idx_q;
                    wcnt_d   = take ? rd_cnt : best_cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vcnt_q     <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            winner_q   <= '0;
            wcnt_q     <= '0;
`ifdef VOTE_TIE_FLAG_EN
            tie_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            vcnt_q     <= vcnt_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_cnt_q <= best_cnt_d;
            winner_q   <= winner_d;
            wcnt_q     <= wcnt_d;
`ifdef VOTE_TIE_FLAG_EN
            tie_q      <= tie_d;
`endif
        end
    end

    assign vote_ready   = (state_q == COLLECT);
    assign busy         = (state_q == COLLECT) || (state_q == SCAN);
    assign done         = (state_q == DONE);
    assign winner       = winner_q;
    assign winner_count = wcnt_q;
`ifdef VOTE_TIE_FLAG_EN
    assign tie          = (state_q == DONE) && tie_q;
`endif

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Bench for vote_tally_ctrl: election-level model plus directed elections.
// Tie checks are active when VOTE_TIE_FLAG_EN is defined.
module tb_vote_tally_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vote_valid = 1'b0;
    logic [1:0] vote = '0;
    logic       vote_ready, busy, done;
    logic [1:0] winner;
    logic [2:0] winner_count;
    logic       tie;

    logic       rst2 = 1'b1;
    logic       start2 = 1'b0;
    logic       vote_valid2 = 1'b0;
    logic [2:0] vote2 = '0;
    logic       vote_ready2, busy2, done2;
    logic [2:0] winner2;
    logic [3:0] winner_count2;
    logic       tie2;

    vote_tally_ctrl #(.N(2), .M(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vote_valid   (vote_valid),
        .vote         (vote),
        .vote_ready   (vote_ready),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_count (winner_count)
`ifdef VOTE_TIE_FLAG_EN
        ,
        .tie          (tie)
`endif
    );

    vote_tally_ctrl #(.N(3), .M(3)) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .start        (start2),
        .vote_valid   (vote_valid2),
        .vote         (vote2),
        .vote_ready   (vote_ready2),
        .busy         (busy2),
        .done         (done2),
        .winner       (winner2),
        .winner_count (winner_count2)
`ifdef VOTE_TIE_FLAG_EN
        ,
        .tie          (tie2)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Election-level model: tallies, accept count, scan countdown.
    int  tally [4];
    int  accepted;
    bit  m_coll, m_done;
    int  m_scan;
    int  e_win, e_cnt;
    bit  e_tie;
    bit  chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            foreach (tally[i]) tally[i] = 0;
            accepted = 0;
            m_coll = 0;
            m_done = 0;
            m_scan = 0;
            e_win = 0;
            e_cnt = 0;
            e_tie = 0;
        end else if (m_scan > 0) begin
            m_scan--;
            if (m_scan == 0) begin
                e_win = 0;
                for (int i = 1; i < 4; i++)
                    if (tally[i] > tally[e_win]) e_win = i;
                e_cnt = tally[e_win];
                e_tie = 0;
                for (int i = 0; i < 4; i++)
                    if (i != e_win && tally[i] == e_cnt) e_tie = 1;
                m_done = 1;
            end
        end else if (m_coll) begin
            if (vote_valid) begin
                tally[vote]++;
                accepted++;
                if (accepted == 4) begin
                    m_coll = 0;
                    m_scan = 4;
                end
            end
        end else if (start) begin
            foreach (tally[i]) tally[i] = 0;
            accepted = 0;
            m_coll = 1;
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("vote_ready", vote_ready, m_coll);
            chk("busy", busy, m_coll || (m_scan > 0));
            chk("done", done, m_done);
            chk("winner", winner, e_win);
            chk("winner_count", winner_count, e_cnt);
`ifdef VOTE_TIE_FLAG_EN
            chk("tie", tie, m_done ? e_tie : 1'b0);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int v);
        vote_valid = 1'b1;
        vote = 2'(v);
        tick();
        vote_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int lat;
    int k;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_winner", winner, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", vote_ready, 0);

        // 1: back-to-back votes, latency check
        do_start();
        send(2); send(1); send(2); send(3);
        wait_done(lat);
        chk("t1_latency", lat, 5);
        chk("t1_winner", winner, 2);
        chk("t1_count", winner_count, 2);
        chk("t1_model_win", e_win, 2);

        // 2: tie between 0 and 3 resolves low
        do_start();
        send(0); send(3); send(3); send(0);
        wait_done(lat);
        chk("t2_winner", winner, 0);
        chk("t2_count", winner_count, 2);
`ifdef VOTE_TIE_FLAG_EN
        chk("t2_tie", tie, 1);
`endif

        // 3: toggling valid, votes offered during SCAN
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(1);
            if (i < 3) begin
                vote = 2'd2;
                tick();
            end
        end
        vote_valid = 1'b1;
        vote = 2'd0;
        tick();
        chk("t3_ready_scan", vote_ready, 0);
        tick();
        vote_valid = 1'b0;
        wait_done(lat);
        chk("t3_winner", winner, 1);
        chk("t3_count", winner_count, 4);
        chk("t3_model_cnt", e_cnt, 4);

        // 4: reset mid-election with simultaneous start
        do_start();
        send(0); send(0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("t4_busy_rst", busy, 0);
        chk("t4_winner_rst", winner, 0);
        do_start();
        send(3); send(3); send(0); send(1);
        wait_done(lat);
        chk("t4_winner", winner, 3);
        chk("t4_count", winner_count, 2);

        // 5: start ignored while busy, honoured in DONE
        do_start();
        send(2);
        start = 1'b1;
        send(2);
        start = 1'b0;
        send(2); send(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_busy_scan", busy, 1);
        chk("t5_done_scan", done, 0);
        wait_done(lat);
        chk("t5_winner", winner, 2);
        chk("t5_count", winner_count, 3);
        do_start();
        chk("t5_restart_busy", busy, 1);
        chk("t5_hold_winner", winner, 2);
        send(1); send(1); send(0); send(3);
        wait_done(lat);
        chk("t5b_winner", winner, 1);
        chk("t5b_count", winner_count, 2);

        // 6: wide configuration, unanimous
        chk_en = 1'b0;
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vote_valid2 = 1'b1;
            vote2 = 3'd7;
            tick();
        end
        vote_valid2 = 1'b0;
        k = 1;
        while (!done2 && k < 40) begin
            tick();
            k++;
        end
        chk("t6_latency", k, 9);
        chk("t6_winner", winner2, 7);
        chk("t6_count", winner_count2, 8);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
